dtm_dmi_master: RTL
===================

// Module: dtm_dmi_master
// PURPOSE
//  DTM-side initiator of the DTM<->DM debug bus (DMI). Converts a dmi DR update from the JTAG TAP
//  (already in sys_clk domain) into one dtm_req_valid/ready transaction, waits for dm_resp, and
//  holds read data plus sticky dmistat for the next DR capture. Sits between jtag_tap and the DM.
// PARAMETERS
//  ABITS     7    DMI address width (= `DBUS_ADDR_WIDTH)
//  DATA_W    32   DMI data width (= `DBUS_DATA_WIDTH)
//  TMO_CYC   255  cycles from request issue to response before the op is declared failed
// PORTS
//  sys_clk        in   1                 system clock; single clock domain
//  sys_rst        in   1                 reset, synchronous, active-high
//  dmi_update     in   1                 1-cycle pulse: new op from TAP update-DR
//  dmi_op_in      in   2                 0 nop, 1 read, 2 write, 3 reserved(=nop)
//  dmi_addr_in    in   ABITS             target DM register address
//  dmi_data_in    in   DATA_W            write data
//  dmi_capture    in   1                 1-cycle pulse: TAP capture-DR of dmi
//  dmireset       in   1                 pulse: clear sticky dmistat
//  dmihardreset   in   1                 pulse: abort outstanding op, clear sticky
//  dtm_req_valid  out  1                 request valid to DM
//  dtm_req_ready  in   1                 DM accepts request
//  dtm_req_bits   out  DATA_W+ABITS+2    {data, addr, op}; op at [1:0], addr at [ABITS+1:2]
//  dm_resp_valid  in   1                 DM response valid
//  dm_resp_ready  out  1                 master accepts response
//  dm_resp_bits   in   DATA_W+2          {status[1:0], rdata}; status 0 ok, 2 failed, 3 busy
//  dmi_rdata      out  DATA_W            last read data (returned on capture)
//  dmistat        out  2                 sticky: 0 none, 2 failed, 3 busy
//  dmi_busy       out  1                 FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; timeout counter 0.
//  FSM IDLE -> REQ -> RESP -> IDLE.
//   IDLE: dmi_update with op 1/2 and dmistat==0 -> latch op/addr/data, go REQ next cycle.
//         op 0/3 or dmistat!=0 -> ignored, no bus traffic.
//   REQ: dtm_req_valid=1, bits stable until dtm_req_valid&&dtm_req_ready -> RESP.
//   RESP: dm_resp_ready=1; on dm_resp_valid: status 0 -> dmi_rdata<=rdata (read ops only;
//         writes leave dmi_rdata unchanged); status 2/3 -> dmistat<=status; -> IDLE.
//  Latency: update at cycle N -> valid at N+1; a 1-cycle ready + same-cycle resp gives IDLE at N+3.
//  Never valid and resp_ready together; dm_resp_valid outside RESP is ignored.
//  Busy violations: dmi_update or dmi_capture while dmi_busy -> dmistat<=3 (unless already
//   nonzero); update op dropped, outstanding op continues unaffected.
//  Timeout: counter runs in REQ/RESP, clears in IDLE; reaching TMO_CYC -> dmistat<=2, -> IDLE,
//   valid/resp_ready drop that cycle (hardreset precedence applies).
//  Sticky: dmistat only cleared by dmireset, dmihardreset or sys_rst; first error wins.
//  dmihardreset: highest priority after sys_rst; FSM->IDLE, valid/resp_ready 0 next cycle,
//   dmistat 0, dmi_rdata kept. dmireset in same cycle as an error: error wins (stays set).
//  Simultaneous dmi_update and dmihardreset: update dropped.
// STRUCTURE
//  Shared dbg_defines.vh: DMI op codes, response status codes, DBUS_* widths, field offsets.
//  One sub-module natural: dmi_tmo_cnt (loadable saturating counter, clear/enable/expire).
// TESTING
//  Read 0x04 (data0): resp {0,0xDEADBEEF} after 2-cycle ready delay -> req bits op=1 addr=0x04,
//   dmi_rdata=0xDEADBEEF, dmistat=0, busy low 1 cycle after resp.
//  Write 0x17 data 0x00221008, ready held low 5 cycles -> valid/bits stable all 5 cycles, 1 handshake.
//  Second update during RESP -> dmistat=3, no second request; later update ignored until dmireset.
//  DM never responds, TMO_CYC=8 -> dmistat=2 exactly 8 cycles after issue, FSM IDLE.
//  dmihardreset mid-REQ -> valid 0 next cycle, dmistat=0, next read proceeds normally.
//  Resp status 2 on write -> dmistat=2, dmi_rdata unchanged; dmireset -> dmistat=0.

Source files
------------

// File: rtl/dtm_dmi_master_pkg.sv
// Shared DMI definitions: operation codes, response/dmistat codes and master FSM states.
package dtm_dmi_master_pkg;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    localparam logic [1:0] DMI_STAT_OK     = 2'd0;
    localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
    localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } dmi_state_e;

    function automatic logic is_bus_op(input logic [1:0] op);
        return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
    endfunction

    // Any non-ok status other than busy (including the reserved code) is reported as failed.
    function automatic logic [1:0] resp_err_code(input logic [1:0] status);
        return (status == DMI_STAT_BUSY) ? DMI_STAT_BUSY : DMI_STAT_FAILED;
    endfunction

endpackage

// File: rtl/dtm_dmi_master_if.sv
// DTM<->DM debug bus: request channel {data, addr, op} and response channel {status, rdata}.
interface dtm_dmi_master_if #(
    parameter int ABITS  = 7,
    parameter int DATA_W = 32
);
    logic                    dtm_req_valid;
    logic                    dtm_req_ready;
    logic [DATA_W+ABITS+1:0] dtm_req_bits;
    logic                    dm_resp_valid;
    logic                    dm_resp_ready;
    logic [DATA_W+1:0]       dm_resp_bits;

    modport master (
        output dtm_req_valid,
        output dtm_req_bits,
        input  dtm_req_ready,
        input  dm_resp_valid,
        input  dm_resp_bits,
        output dm_resp_ready
    );

    modport slave (
        input  dtm_req_valid,
        input  dtm_req_bits,
        output dtm_req_ready,
        output dm_resp_valid,
        output dm_resp_bits,
        input  dm_resp_ready
    );
endinterface

// File: rtl/dtm_dmi_master_tmo_cnt.sv
// Saturating cycle counter for the outstanding DMI op; expire fires on the cycle whose
// increment would bring the count to MAX, so the op is abandoned after exactly MAX busy cycles.
module dmi_tmo_cnt #(
    parameter int MAX = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == W'(MAX - 1));

endmodule

// File: rtl/dtm_dmi_master.sv
// DTM-side DMI initiator: turns one TAP dmi update into a single request/response exchange
// with the DM and holds read data plus sticky dmistat for the next DR capture.
module dtm_dmi_master
    import dtm_dmi_master_pkg::*;
#(
    parameter int ABITS   = 7,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              dmi_update,
    input  logic [1:0]        dmi_op_in,
    input  logic [ABITS-1:0]  dmi_addr_in,
    input  logic [DATA_W-1:0] dmi_data_in,
    input  logic              dmi_capture,
    input  logic              dmireset,
    input  logic              dmihardreset,
    dtm_dmi_master_if.master  dmi_bus,
    output logic [DATA_W-1:0] dmi_rdata,
    output logic [1:0]        dmistat,
    output logic              dmi_busy
);

    dmi_state_e        state_q;
    dmi_state_e        state_d;
    logic [1:0]        op_q;
    logic [ABITS-1:0]  addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy;
    logic              tmo_expire;
    logic              req_valid;
    logic              resp_ready;
    logic              accept;
    logic              load_rdata;
    logic              err_set;
    logic [1:0]        err_code;
    logic [1:0]        resp_status;

    assign busy        = (state_q != ST_IDLE);
    assign resp_status = dmi_bus.dm_resp_bits[DATA_W+1:DATA_W];

    dmi_tmo_cnt #(
        .MAX (TMO_CYC)
    ) u_tmo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (!busy),
        .en      (busy),
        .expire  (tmo_expire)
    );

    // Error priority within a cycle: timeout, then DM status, then TAP access while busy.
    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        accept     = 1'b0;
        load_rdata = 1'b0;
        err_set    = 1'b0;
        err_code   = DMI_STAT_OK;
        case (state_q)
            ST_IDLE: begin
                if (dmi_update && is_bus_op(dmi_op_in) && (dmistat == DMI_STAT_OK)) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = !tmo_expire;
                if (tmo_expire) begin
                    state_d  = ST_IDLE;
                    err_set  = 1'b1;
                    err_code = DMI_STAT_FAILED;
                end else if (dmi_bus.dtm_req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_ready = !tmo_expire;
                if (tmo_expire) begin
                    state_d  = ST_IDLE;
                    err_set  = 1'b1;
                    err_code = DMI_STAT_FAILED;
                end else if (dmi_bus.dm_resp_valid) begin
                    state_d = ST_IDLE;
                    if (resp_status == DMI_STAT_OK) begin
                        load_rdata = (op_q == DMI_OP_READ);
                    end else begin
                        err_set  = 1'b1;
                        err_code = resp_err_code(resp_status);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!err_set && busy && (dmi_update || dmi_capture)) begin
            err_set  = 1'b1;
            err_code = DMI_STAT_BUSY;
        end
        if (dmihardreset) begin
            state_d    = ST_IDLE;
            accept     = 1'b0;
            load_rdata = 1'b0;
        end
    end

    // A dmireset coinciding with a new error clears the old code and keeps the new one.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            dmi_rdata <= '0;
            dmistat   <= DMI_STAT_OK;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= dmi_op_in;
                addr_q <= dmi_addr_in;
                data_q <= dmi_data_in;
            end
            if (load_rdata) begin
                dmi_rdata <= dmi_bus.dm_resp_bits[DATA_W-1:0];
            end
            if (dmihardreset) begin
                dmistat <= DMI_STAT_OK;
            end else if (err_set && ((dmistat == DMI_STAT_OK) || dmireset)) begin
                dmistat <= err_code;
            end else if (dmireset) begin
                dmistat <= DMI_STAT_OK;
            end
        end
    end

    assign dmi_bus.dtm_req_valid = req_valid;
    assign dmi_bus.dm_resp_ready = resp_ready;
    assign dmi_bus.dtm_req_bits  = {data_q, addr_q, op_q};
    assign dmi_busy              = busy;

endmodule
